// File: rtl/wb_gpio_irq_ctrl.sv
// Wishbone GPIO controller: per-pin OUT/OEB, synced IN, edge IRQs.
// Optional input debounce filter enabled with `define GPIO_DEBOUNCE_EN.
module wb_gpio_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          NUM_IO     = 38,
  parameter int          NUM_IRQ    = 3,
  parameter int          DEBOUNCE_W = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [NUM_IO-1:0]  io_in,
  output logic [NUM_IO-1:0]  io_out,
  output logic [NUM_IO-1:0]  io_oeb,
  output logic [NUM_IRQ-1:0] user_irq
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] in_q, in_d;
  logic [NUM_IO-1:0] ien_q, ien_d;
  logic [NUM_IO-1:0] istat_q, istat_d;
  logic [NUM_IO-1:0] iedge_q, iedge_d;
  logic [NUM_IO-1:0] sync1_q, sync2_q;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IO-1:0] filt;
  logic              unused_ok;

`ifdef GPIO_DEBOUNCE_EN
  logic [NUM_IO-1:0]     filt_q, filt_d;
  logic [DEBOUNCE_W-1:0] cnt_q [NUM_IO];
  logic [DEBOUNCE_W-1:0] cnt_d [NUM_IO];

  // Accept a new level only after it has been stable for 2**W cycles.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_IO; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == '1) filt_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
      end
    end
  end

  // Debounce state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_IO; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NUM_IO; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt      = filt_q;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
`else
  assign filt      = sync2_q;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], (DEBOUNCE_W > 0)};
`endif

  logic        req, hit, wr;
  logic [4:0]  reg_idx;
  logic [31:0] m32;
  logic [63:0] m64, wd64, rd64;
  logic [63:0] out64, oeb64, in64, ien64, ist64, iedge64;
  logic [NUM_IO-1:0] m, wd, set;

  // Bus decode, register writes, read mux and edge detection.
  always_comb begin
    req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    hit     = wbs_adr_i[31:8] == BASE_ADDR[31:8];
    wr      = req & wbs_we_i & hit;
    reg_idx = wbs_adr_i[7:3];
    m32     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
               {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    m64     = wbs_adr_i[2] ? {m32, 32'h0} : {32'h0, m32};
    wd64    = {wbs_dat_i, wbs_dat_i};
    m       = m64[NUM_IO-1:0];
    wd      = wd64[NUM_IO-1:0] & m;

    out64   = '0; out64[NUM_IO-1:0]   = out_q;
    oeb64   = '0; oeb64[NUM_IO-1:0]   = oeb_q;
    in64    = '0; in64[NUM_IO-1:0]    = in_q;
    ien64   = '0; ien64[NUM_IO-1:0]   = ien_q;
    ist64   = '0; ist64[NUM_IO-1:0]   = istat_q;
    iedge64 = '0; iedge64[NUM_IO-1:0] = iedge_q;

    case (reg_idx)
      5'd0:    rd64 = out64;
      5'd1:    rd64 = oeb64;
      5'd2:    rd64 = in64;
      5'd3:    rd64 = ien64;
      5'd4:    rd64 = ist64;
      5'd5:    rd64 = iedge64;
      default: rd64 = '0;
    endcase

    ack_d = req;
    dat_d = '0;
    if (req && !wbs_we_i && hit)
      dat_d = wbs_adr_i[2] ? rd64[63:32] : rd64[31:0];

    out_d   = out_q;
    oeb_d   = oeb_q;
    ien_d   = ien_q;
    iedge_d = iedge_q;
    if (wr && reg_idx == 5'd0) out_d   = (out_q & ~m) | wd;
    if (wr && reg_idx == 5'd1) oeb_d   = (oeb_q & ~m) | wd;
    if (wr && reg_idx == 5'd3) ien_d   = (ien_q & ~m) | wd;
    if (wr && reg_idx == 5'd5) iedge_d = (iedge_q & ~m) | wd;

    in_d = filt;
    set  = (~iedge_q & filt & ~in_q) | (iedge_q & ~filt & in_q);
    istat_d = istat_q;
    if (wr && reg_idx == 5'd4) istat_d = istat_q & ~wd;
    istat_d = istat_d | set;

    irq_d = '0;
    for (int k = 0; k < NUM_IRQ; k++)
      for (int i = 0; i < NUM_IO; i++)
        if (i % NUM_IRQ == k)
          irq_d[k] = irq_d[k] | (istat_q[i] & ien_q[i]);
  end

  // All architectural state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      in_q    <= '0;
      ien_q   <= '0;
      istat_q <= '0;
      iedge_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      irq_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      in_q    <= in_d;
      ien_q   <= ien_d;
      istat_q <= istat_d;
      iedge_q <= iedge_d;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign user_irq  = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// Directed bench for wb_gpio_irq_ctrl (NUM_IO=38, NUM_IRQ=3).
// Expected values are hand-computed constants.
module tb_wb_gpio_irq_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, wdat = 0;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_in = 0;
  logic [37:0] io_out, io_oeb;
  logic [2:0]  irq;
  logic [31:0] rd;
  int checks = 0;
  int errors = 0;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif

  wb_gpio_irq_ctrl dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .user_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    chk("ack_hi", {63'b0, ack}, 64'd1);
    r = rdat;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_lo", {63'b0, ack}, 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] e);
    logic [31:0] r;
    xfer(1'b0, a, 32'h0, 4'h0, r);
    chk(tag, {32'b0, r}, {32'b0, e});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    xfer(1'b1, a, d, s, r);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {63'b0, ack}, 64'd0);
    chk("rst_dat", {32'b0, rdat}, 64'd0);
    chk("rst_oeb", {26'b0, io_oeb}, {26'b0, 38'h3F_FFFF_FFFF});
    chk("rst_out", {26'b0, io_out}, 64'd0);
    chk("rst_irq", {61'b0, irq}, 64'd0);
    @(negedge clk); rst_n = 1;

    rd_chk("oeb_lo", 32'h3000_0008, 32'hFFFF_FFFF);
    rd_chk("oeb_hi", 32'h3000_000C, 32'h0000_003F);
    rd_chk("out_lo", 32'h3000_0000, 32'h0);

    wr(32'h3000_0000, 32'hA5A5_A5A5, 4'b0011);
    rd_chk("out_sel", 32'h3000_0000, 32'h0000_A5A5);
    chk("io_out", {26'b0, io_out}, 64'h0000_A5A5);

    wr(32'h3000_0004, 32'hFFFF_FFFF, 4'hF);
    rd_chk("out_hi", 32'h3000_0004, 32'h0000_003F);
    wr(32'h3000_000C, 32'h0, 4'hF);
    chk("oeb_pins", {26'b0, io_oeb}, {26'b0, 38'h00_FFFF_FFFF});

    wr(32'h3000_0018, 32'h20, 4'hF);
    @(negedge clk); io_in[5] = 1;
    repeat (LAT) @(posedge clk);
    #1 chk("irq_lag", {61'b0, irq}, 64'd0);
    @(posedge clk);
    #1 chk("irq_set", {61'b0, irq}, 64'b100);
    rd_chk("in_lo", 32'h3000_0010, 32'h20);
    rd_chk("istat", 32'h3000_0020, 32'h20);
    wr(32'h3000_0020, 32'h20, 4'hF);
    chk("irq_clr", {61'b0, irq}, 64'd0);
    rd_chk("istat_clr", 32'h3000_0020, 32'h0);

    @(negedge clk); io_in[5] = 0;
    repeat (LAT + 4) @(posedge clk);
    rd_chk("fall_ign", 32'h3000_0020, 32'h0);
    @(negedge clk); io_in[5] = 1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0020;
    wdat = 32'h20; sel = 4'hF;
    @(posedge clk); #1;
    chk("w1c_ack", {63'b0, ack}, 64'd1);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk);
    rd_chk("set_wins", 32'h3000_0020, 32'h20);

    rd_chk("oow_rd", 32'h3000_0100, 32'h0);
    rd_chk("hole_rd", 32'h3000_0030, 32'h0);
    wr(32'h3000_0100, 32'hFFFF_FFFF, 4'hF);
    wr(32'h3000_0030, 32'hFFFF_FFFF, 4'hF);
    rd_chk("no_chg", 32'h3000_0000, 32'h0000_A5A5);

    wr(32'h3000_0028, 32'h1, 4'hF);
    @(negedge clk); io_in[0] = 1;
    repeat (LAT + 2) @(posedge clk);
    rd_chk("rise_ign", 32'h3000_0020, 32'h20);
    @(negedge clk); io_in[0] = 0;
    repeat (LAT + 2) @(posedge clk);
    rd_chk("fall_det", 32'h3000_0020, 32'h21);

`ifdef GPIO_DEBOUNCE_EN
    @(negedge clk); io_in[1] = 1;
    repeat (10) @(negedge clk);
    io_in[1] = 0;
    repeat (30) @(posedge clk);
    rd_chk("glitch", 32'h3000_0010, 32'h20);
    @(negedge clk); io_in[1] = 1;
    repeat (20) @(negedge clk);
    io_in[1] = 0;
    repeat (2) @(posedge clk);
    rd_chk("pulse", 32'h3000_0010, 32'h22);
`endif

    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0000;
    @(posedge clk); #1;
    chk("mid_ack", {63'b0, ack}, 64'd1);
    rst_n = 0;
    #1;
    chk("abort_ack", {63'b0, ack}, 64'd0);
    chk("abort_oeb", {26'b0, io_oeb}, {26'b0, 38'h3F_FFFF_FFFF});
    cyc = 0; stb = 0;
    @(negedge clk); rst_n = 1;
    rd_chk("post_rst", 32'h3000_0000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
